bnn_window_ctrl: RTL and testbench
==================================

Name: bnn_window_ctrl

Overview:
- Sequences two cascaded 1-bit line buffers (`line_buffer`, depth 14) to turn a raster-order binary pixel stream into 3x3 binary windows for the BNN XNOR-popcount stage.
- Every line-buffer operation comes from this controller: enable, read, write and clear.
- Assembles each KxK window from the line-buffer taps and the incoming pixel.
- Each `line_buffer` does at most one operation per cycle, and write wins over read. Each pixel therefore takes a read cycle followed by a write cycle.

Parameters:
- K, 3, window size. Fixed at 3 in this revision; K-1 line buffers.
- IMG_W, 14, image width in pixels. Must satisfy K <= IMG_W <= LB_DEPTH.
- IMG_H, 14, image height in rows. Must satisfy IMG_H >= K.
- LB_DEPTH, 14, line-buffer capacity in bits.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- start  in  1  begin a frame. Sampled in IDLE only.
- pix_valid  in  1  input pixel valid
- pix_in  in  1  binary pixel
- pix_ready  out  1  controller accepts a pixel this cycle
- lb_en  out  2  per-buffer enable
- lb_rst  out  2  per-buffer clear
- lb_wr  out  2  per-buffer write strobe
- lb_rd  out  2  per-buffer read strobe
- lb_din  out  2  data to buffers. [0]=pixel; [1]=lb_dout[0].
- lb_dout  in  2  registered outputs of the buffers
- lb_empty  in  2  buffer empty flags
- lb_full  in  2  buffer full flags
- win  out  9  window, win[r*3+c]. r=0 is the oldest row; c=0 is the leftmost column.
- win_valid  out  1  one-cycle strobe: win holds a new complete window
- frame_done  out  1  one-cycle strobe at end of frame
- busy  out  1  high in any state except IDLE

Behaviour:
- States: IDLE, RD, WR, FLUSH.
- Reset:
  - State goes to IDLE; row and col are 0; win=0.
  - pix_ready, win_valid, frame_done, busy, lb_wr, lb_rd are 0.
  - While rst is high, lb_en=2'b11 and lb_rst=2'b11, which also clears the buffers.
  - Reset mid-frame abandons the frame. No frame_done is issued.
- IDLE:
  - start=1 moves to RD and clears row and col.
  - pix_valid is ignored.
- RD:
  - pix_ready=1. Accept = pix_valid & pix_ready.
  - On accept: lb_rd[i]=1 and lb_en[i]=1 for every i with row > i. Latch pix_in, go to WR.
  - With no accept: stay in RD, and all lb strobes are 0.
- WR:
  - pix_ready=0.
  - lb_wr[0]=1 with lb_din[0] set to the latched pixel.
  - lb_wr[1]=1 only when row >= 1, with lb_din[1]=lb_dout[0], which was read in the previous cycle.
  - Window shift: each row register shifts left by one. The new column is row2←pixel, row1←lb_dout[0], row0←lb_dout[1].
  - col increments; at IMG_W-1 it wraps to 0 and row increments.
  - Next state is RD, or FLUSH if this was row IMG_H-1, col IMG_W-1.
- win_valid:
  - Registered, high in the cycle after a WR whose pre-increment row >= 2 and col >= 2.
  - Latency: accept at cycle t, win_valid at t+2.
  - Throughput: at most 1 pixel per 2 cycles.
- FLUSH:
  - One cycle with lb_en=lb_rst=2'b11.
  - frame_done=1 in this same cycle.
  - Next state is IDLE.
- start while busy is ignored.
- The pix_valid/pix_in values are don't-care outside an accept.
- Window count per frame is (IMG_W-2)*(IMG_H-2).
- Buffer occupancy: in steady state each buffer holds exactly IMG_W bits, because it sees one read and one write per pixel.

Optional Feature:
- Macro: BNN_LB_ERRCHK_EN.
- When defined:
  - Adds output err (1 bit, sticky).
  - err sets when a read strobe is issued with the matching lb_empty=1, or a write strobe with the matching lb_full=1.
  - err clears only on rst.
- When undefined: no err port and no check logic. Behaviour is otherwise identical.

Decomposition:
- Package bnn_pkg holds:
  - K, IMG_W, IMG_H, LB_DEPTH defaults.
  - State encoding as a 2-bit localparam set: IDLE=0, RD=1, WR=2, FLUSH=3.
- One natural sub-module: bnn_win_reg, the 3x3 shift register with shift enable and a 3-bit column input.
- FSM, counters and lb strobe decode stay in bnn_window_ctrl.

Test Plan:
- Ramp a 4x4 image (IMG_W=IMG_H=4), pixel = (row+col)&1, pix_valid held high:
  - exactly 4 win_valid pulses;
  - first window win=9'b010_101_010 (check by bit position);
  - frame_done exactly 1 cycle after the last WR.
- All-ones 14x14 frame: 144 win_valid pulses, each with win=9'h1FF; busy falls the cycle after frame_done.
- Random pix_valid gaps (50% duty) on a random image: windows match the reference model, and no lb strobe fires in stalled RD cycles.
- Reset at row 5, col 7 of a 14x14 frame, then start again:
  - lb_rst=2'b11 during rst;
  - no frame_done from the aborted frame;
  - the next frame's windows are correct.
- start pulsed during busy: ignored, and the frame completes normally with a single frame_done.
- With BNN_LB_ERRCHK_EN, tie lb_empty[1]=1 during a row-2 read: err=1 the next cycle and stays high until rst.

Source files
------------

// File: rtl/bnn_pkg.sv
// Shared constants and FSM state encoding for the BNN 3x3 window controller.
package bnn_pkg;

    localparam int unsigned K         = 3;
    localparam int unsigned IMG_W_DEF = 14;
    localparam int unsigned IMG_H_DEF = 14;
    localparam int unsigned LB_DEPTH  = 14;

    localparam int unsigned NUM_LB = K - 1;
    localparam int unsigned WIN_W  = K * K;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RD    = 2'd1;
    localparam logic [1:0] ST_WR    = 2'd2;
    localparam logic [1:0] ST_FLUSH = 2'd3;

endpackage

// File: rtl/bnn_window_ctrl_if.sv
// Pixel-stream, line-buffer and window signals between the controller (master) and its environment (slave).
interface bnn_window_ctrl_if;
    import bnn_pkg::*;

    logic              start;
    logic              pix_valid;
    logic              pix_in;
    logic              pix_ready;
    logic [NUM_LB-1:0] lb_en;
    logic [NUM_LB-1:0] lb_rst;
    logic [NUM_LB-1:0] lb_wr;
    logic [NUM_LB-1:0] lb_rd;
    logic [NUM_LB-1:0] lb_din;
    logic [NUM_LB-1:0] lb_dout;
    logic [NUM_LB-1:0] lb_empty;
    logic [NUM_LB-1:0] lb_full;
    logic [WIN_W-1:0]  win;
    logic              win_valid;
    logic              frame_done;
    logic              busy;

    modport master (
        input  start, pix_valid, pix_in, lb_dout, lb_empty, lb_full,
        output pix_ready, lb_en, lb_rst, lb_wr, lb_rd, lb_din,
               win, win_valid, frame_done, busy
    );

    modport slave (
        output start, pix_valid, pix_in, lb_dout, lb_empty, lb_full,
        input  pix_ready, lb_en, lb_rst, lb_wr, lb_rd, lb_din,
               win, win_valid, frame_done, busy
    );

endinterface

// File: rtl/bnn_win_reg.sv
// KxK binary window shift register; each shift drops the leftmost column and appends col_i on the right.
module bnn_win_reg
    import bnn_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             shift_i,
    input  logic [K-1:0]     col_i,
    output logic [WIN_W-1:0] win_o
);

    logic [WIN_W-1:0] win_q;

    // Row r lives in win_q[r*K +: K]; bit c=0 is the oldest column.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_q <= '0;
        end else if (shift_i) begin
            for (int unsigned r = 0; r < K; r++) begin
                win_q[r*K +: K] <= {col_i[r], win_q[r*K+1 +: K-1]};
            end
        end
    end

    assign win_o = win_q;

endmodule

// File: rtl/bnn_window_ctrl.sv
// Raster-stream to 3x3 window controller driving two cascaded 1-bit line buffers.
// Optional BNN_LB_ERRCHK_EN adds a sticky err output for empty-read / full-write strobes.
module bnn_window_ctrl
    import bnn_pkg::*;
#(
    parameter int unsigned IMG_W = IMG_W_DEF,
    parameter int unsigned IMG_H = IMG_H_DEF
) (
    input  logic clk,
    input  logic rst,
`ifdef BNN_LB_ERRCHK_EN
    output logic err,
`endif
    bnn_window_ctrl_if.master bus
);

    localparam int unsigned CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic          pix_q, pix_d;
    logic          pix_ready_q, win_valid_q, frame_done_q, busy_q;

    logic              accept_c, last_col_c, shift_c;
    logic [K-1:0]      win_col_c;
    logic [NUM_LB-1:0] lb_en_c, lb_rst_c, lb_wr_c, lb_rd_c;

    assign accept_c   = (state_q == ST_RD) && bus.pix_valid;
    assign last_col_c = (col_q == CW'(IMG_W - 1));
    assign shift_c    = (state_q == ST_WR);
    // Newest row is the live pixel; lb_dout[1] holds the oldest row.
    assign win_col_c  = {pix_q, bus.lb_dout[0], bus.lb_dout[1]};

    // Next-state and counter update.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        pix_d   = pix_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_RD;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            ST_RD: begin
                if (accept_c) begin
                    pix_d   = bus.pix_in;
                    state_d = ST_WR;
                end
            end
            ST_WR: begin
                state_d = ST_RD;
                if (last_col_c) begin
                    col_d = '0;
                    if (row_q == RW'(IMG_H - 1)) state_d = ST_FLUSH;
                    else                         row_d   = row_q + RW'(1);
                end else begin
                    col_d = col_q + CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Line-buffer strobes: read on accept, write the following cycle, clear on reset/flush.
    always_comb begin
        lb_en_c  = '0;
        lb_rst_c = '0;
        lb_wr_c  = '0;
        lb_rd_c  = '0;
        if (rst) begin
            lb_en_c  = '1;
            lb_rst_c = '1;
        end else begin
            case (state_q)
                ST_RD: begin
                    for (int unsigned i = 0; i < NUM_LB; i++) begin
                        if (accept_c && (row_q > RW'(i))) begin
                            lb_en_c[i] = 1'b1;
                            lb_rd_c[i] = 1'b1;
                        end
                    end
                end
                ST_WR: begin
                    for (int unsigned i = 0; i < NUM_LB; i++) begin
                        if (row_q >= RW'(i)) begin
                            lb_en_c[i] = 1'b1;
                            lb_wr_c[i] = 1'b1;
                        end
                    end
                end
                ST_FLUSH: begin
                    lb_en_c  = '1;
                    lb_rst_c = '1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            row_q        <= '0;
            col_q        <= '0;
            pix_q        <= 1'b0;
            pix_ready_q  <= 1'b0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            col_q        <= col_d;
            pix_q        <= pix_d;
            pix_ready_q  <= (state_d == ST_RD);
            win_valid_q  <= shift_c && (row_q >= RW'(2)) && (col_q >= CW'(2));
            frame_done_q <= (state_d == ST_FLUSH);
            busy_q       <= (state_d != ST_IDLE);
        end
    end

    bnn_win_reg u_win_reg (
        .clk     (clk),
        .rst     (rst),
        .shift_i (shift_c),
        .col_i   (win_col_c),
        .win_o   (bus.win)
    );

`ifdef BNN_LB_ERRCHK_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if ((|(lb_rd_c & bus.lb_empty)) || (|(lb_wr_c & bus.lb_full))) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    logic unused_lb_flags;
    assign unused_lb_flags = ^{bus.lb_empty, bus.lb_full};
`endif

    assign bus.pix_ready  = pix_ready_q;
    assign bus.win_valid  = win_valid_q;
    assign bus.frame_done = frame_done_q;
    assign bus.busy       = busy_q;
    assign bus.lb_en      = lb_en_c;
    assign bus.lb_rst     = lb_rst_c;
    assign bus.lb_wr      = lb_wr_c;
    assign bus.lb_rd      = lb_rd_c;
    assign bus.lb_din     = {bus.lb_dout[0], pix_q};

endmodule

// File: tb/tb_bnn_window_ctrl.sv
// Directed bench for bnn_window_ctrl: a 4x4 and a 14x14 instance, each with behavioural line buffers.
module tb_bnn_window_ctrl;
    import bnn_pkg::*;

    localparam int LBD = int'(LB_DEPTH);

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic pv = 1'b0;
    logic pi = 1'b0;
    logic sel = 1'b0;
    logic force_empty = 1'b0;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    bnn_window_ctrl_if bus4 ();
    bnn_window_ctrl_if bus14 ();

`ifdef BNN_LB_ERRCHK_EN
    logic err4, err14;
`endif

    bnn_window_ctrl #(.IMG_W(4), .IMG_H(4)) dut4 (
        .clk (clk),
        .rst (rst),
`ifdef BNN_LB_ERRCHK_EN
        .err (err4),
`endif
        .bus (bus4)
    );

    bnn_window_ctrl #(.IMG_W(14), .IMG_H(14)) dut14 (
        .clk (clk),
        .rst (rst),
`ifdef BNN_LB_ERRCHK_EN
        .err (err14),
`endif
        .bus (bus14)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign bus4.start      = start & ~sel;
    assign bus14.start     = start & sel;
    assign bus4.pix_valid  = pv;
    assign bus14.pix_valid = pv;
    assign bus4.pix_in     = pi;
    assign bus14.pix_in    = pi;

    // Behavioural line buffers: FIFO, write wins over read, registered dout.
    logic [15:0] v4 [2];
    logic [15:0] v14 [2];
    int c4 [2];
    int c14 [2];
    logic [1:0] d4, d14;

    always @(posedge clk) begin
        for (int b = 0; b < 2; b++) begin
            if (bus4.lb_en[b]) begin
                if (bus4.lb_rst[b]) begin
                    c4[b] <= 0; v4[b] <= '0; d4[b] <= 1'b0;
                end else if (bus4.lb_wr[b]) begin
                    if (c4[b] < LBD) begin v4[b][c4[b]] <= bus4.lb_din[b]; c4[b] <= c4[b] + 1; end
                end else if (bus4.lb_rd[b]) begin
                    if (c4[b] > 0) begin d4[b] <= v4[b][0]; v4[b] <= v4[b] >> 1; c4[b] <= c4[b] - 1; end
                end
            end
        end
    end

    always @(posedge clk) begin
        for (int b = 0; b < 2; b++) begin
            if (bus14.lb_en[b]) begin
                if (bus14.lb_rst[b]) begin
                    c14[b] <= 0; v14[b] <= '0; d14[b] <= 1'b0;
                end else if (bus14.lb_wr[b]) begin
                    if (c14[b] < LBD) begin v14[b][c14[b]] <= bus14.lb_din[b]; c14[b] <= c14[b] + 1; end
                end else if (bus14.lb_rd[b]) begin
                    if (c14[b] > 0) begin d14[b] <= v14[b][0]; v14[b] <= v14[b] >> 1; c14[b] <= c14[b] - 1; end
                end
            end
        end
    end

    assign bus4.lb_dout   = d4;
    assign bus4.lb_empty  = {c4[1] == 0, c4[0] == 0};
    assign bus4.lb_full   = {c4[1] == LBD, c4[0] == LBD};
    assign bus14.lb_dout  = d14;
    assign bus14.lb_empty = {(c14[1] == 0) || force_empty, c14[0] == 0};
    assign bus14.lb_full  = {c14[1] == LBD, c14[0] == LBD};

    // Observed signals of the currently selected instance.
    logic       m_pr, m_wv, m_fd, m_busy, m_err;
    logic [1:0] m_en, m_lbrst, m_wr, m_rd;
    logic [8:0] m_win;
    assign m_pr    = sel ? bus14.pix_ready  : bus4.pix_ready;
    assign m_wv    = sel ? bus14.win_valid  : bus4.win_valid;
    assign m_fd    = sel ? bus14.frame_done : bus4.frame_done;
    assign m_busy  = sel ? bus14.busy       : bus4.busy;
    assign m_en    = sel ? bus14.lb_en      : bus4.lb_en;
    assign m_lbrst = sel ? bus14.lb_rst     : bus4.lb_rst;
    assign m_wr    = sel ? bus14.lb_wr      : bus4.lb_wr;
    assign m_rd    = sel ? bus14.lb_rd      : bus4.lb_rd;
    assign m_win   = sel ? bus14.win        : bus4.win;
`ifdef BNN_LB_ERRCHK_EN
    assign m_err   = sel ? err14 : err4;
`else
    assign m_err   = 1'b0;
`endif

    logic [8:0] got_win [$];
    int fd_cnt, fd_cyc, last_wr_cyc, busy_fall_cyc, stall_viol;
    logic busy_prev = 1'b0;
    logic img [14][14];

    // Recorder sampling on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (m_wv) got_win.push_back(m_win);
            if (m_fd) begin fd_cnt++; fd_cyc = cyc; end
            if (m_wr[0]) last_wr_cyc = cyc;
            if (busy_prev && !m_busy) busy_fall_cyc = cyc;
            if (m_pr && !pv && ((m_rd | m_wr | m_en) != 2'b00)) stall_viol++;
        end
        busy_prev = m_busy;
    end

    function automatic logic [8:0] exp_win(input int r, input int c);
        logic [8:0] e;
        for (int rr = 0; rr < 3; rr++)
            for (int cc = 0; cc < 3; cc++)
                e[rr*3+cc] = img[r-2+rr][c-2+cc];
        return e;
    endfunction

    task automatic fill_random(input int w, input int h);
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++)
                img[r][c] = 1'($urandom_range(0, 1));
    endtask

    // Feeds one frame; stops early at stop_idx, raises start again at start_at.
    task automatic run_frame(input int w, input int h, input bit gaps, input int stop_idx, input int start_at);
        int idx = 0;
        int budget = 0;
        got_win.delete();
        fd_cnt = 0; stall_viol = 0; fd_cyc = -1; last_wr_cyc = -1; busy_fall_cyc = -1;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        while (idx < w*h && idx != stop_idx && budget < 6*w*h + 20) begin
            start = (idx == start_at);
            if (m_pr) begin
                pv = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
                pi = img[idx / w][idx % w];
                if (pv) idx++;
            end else begin
                pv = 1'b0;
                pi = 1'($urandom_range(0, 1));
            end
            @(posedge clk); #1;
            budget++;
        end
        pv = 1'b0; start = 1'b0;
        n_vec++;
        if (idx != stop_idx && idx < w*h) begin
            n_err++;
            $display("FAIL feed: accepted %0d pixels, required %0d", idx, w*h);
        end
        if (stop_idx < 0) begin
            for (int i = 0; i < 10 && m_busy; i++) begin @(posedge clk); #1; end
            @(negedge clk); #1;
            n_vec++;
            if (m_busy !== 1'b0) begin
                n_err++;
                $display("FAIL busy_end: busy=%b, required 0", m_busy);
            end
        end
    endtask

    task automatic test_reset();
        sel = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vec++; if (m_en !== 2'b11)    begin n_err++; $display("FAIL rst_lb_en: %b, required 11", m_en); end
        n_vec++; if (m_lbrst !== 2'b11) begin n_err++; $display("FAIL rst_lb_rst: %b, required 11", m_lbrst); end
        @(posedge clk); #1 rst = 1'b0; pv = 1'b1; pi = 1'b1;
        @(negedge clk);
        n_vec++; if (m_pr !== 1'b0)    begin n_err++; $display("FAIL rst_pix_ready: %b, required 0", m_pr); end
        n_vec++; if (m_busy !== 1'b0)  begin n_err++; $display("FAIL rst_busy: %b, required 0", m_busy); end
        n_vec++; if (m_wv !== 1'b0)    begin n_err++; $display("FAIL rst_win_valid: %b, required 0", m_wv); end
        n_vec++; if (m_fd !== 1'b0)    begin n_err++; $display("FAIL rst_frame_done: %b, required 0", m_fd); end
        n_vec++; if (m_win !== 9'h000) begin n_err++; $display("FAIL rst_win: %h, required 000", m_win); end
        n_vec++; if ((m_en | m_rd | m_wr) !== 2'b00) begin n_err++; $display("FAIL idle_strobes: en=%b rd=%b wr=%b, required 0", m_en, m_rd, m_wr); end
        n_vec++; if (m_err !== 1'b0)   begin n_err++; $display("FAIL rst_err: %b, required 0", m_err); end
        @(posedge clk); #1 pv = 1'b0; pi = 1'b0;
    endtask

    task automatic test_ramp4();
        logic [8:0] first_exp = 9'b010_101_010;
        int k = 0;
        sel = 1'b0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                img[r][c] = 1'((r + c) & 1);
        run_frame(4, 4, 1'b0, -1, -1);
        n_vec++; if (got_win.size() != 4) begin n_err++; $display("FAIL ramp_count: %0d windows, required 4", got_win.size()); end
        n_vec++; if (got_win.size() > 0 && got_win[0] !== first_exp) begin n_err++; $display("FAIL ramp_first: %b, required %b", got_win[0], first_exp); end
        for (int r = 2; r < 4; r++)
            for (int c = 2; c < 4; c++) begin
                n_vec++;
                if (k >= got_win.size() || got_win[k] !== exp_win(r, c)) begin
                    n_err++; $display("FAIL ramp_win%0d: %b, required %b", k, (k < got_win.size()) ? got_win[k] : 9'hx, exp_win(r, c));
                end
                k++;
            end
        n_vec++; if (fd_cnt != 1) begin n_err++; $display("FAIL ramp_fd_count: %0d, required 1", fd_cnt); end
        n_vec++; if (fd_cyc - last_wr_cyc != 1) begin n_err++; $display("FAIL ramp_fd_lat: %0d cycles after last WR, required 1", fd_cyc - last_wr_cyc); end
    endtask

    task automatic test_all_ones();
        int bad = 0;
        sel = 1'b1;
        for (int r = 0; r < 14; r++)
            for (int c = 0; c < 14; c++)
                img[r][c] = 1'b1;
        run_frame(14, 14, 1'b0, -1, -1);
        n_vec++; if (got_win.size() != 144) begin n_err++; $display("FAIL ones_count: %0d windows, required 144", got_win.size()); end
        foreach (got_win[i]) begin
            n_vec++;
            if (got_win[i] !== 9'h1FF) begin
                n_err++; bad++;
                if (bad < 4) $display("FAIL ones_win%0d: %h, required 1ff", i, got_win[i]);
            end
        end
        n_vec++; if (busy_fall_cyc - fd_cyc != 1) begin n_err++; $display("FAIL ones_busy_fall: %0d cycles after frame_done, required 1", busy_fall_cyc - fd_cyc); end
    endtask

    task automatic test_random_gaps();
        int k = 0;
        sel = 1'b1;
        fill_random(14, 14);
        run_frame(14, 14, 1'b1, -1, -1);
        n_vec++; if (got_win.size() != 144) begin n_err++; $display("FAIL gaps_count: %0d windows, required 144", got_win.size()); end
        for (int r = 2; r < 14; r++)
            for (int c = 2; c < 14; c++) begin
                n_vec++;
                if (k >= got_win.size() || got_win[k] !== exp_win(r, c)) begin
                    n_err++; $display("FAIL gaps_win%0d: %b, required %b", k, (k < got_win.size()) ? got_win[k] : 9'hx, exp_win(r, c));
                end
                k++;
            end
        n_vec++; if (stall_viol != 0) begin n_err++; $display("FAIL gaps_stall_strobe: %0d stalled cycles with strobes, required 0", stall_viol); end
        n_vec++; if (fd_cnt != 1) begin n_err++; $display("FAIL gaps_fd_count: %0d, required 1", fd_cnt); end
    endtask

    task automatic test_reset_midframe();
        int k = 0;
        sel = 1'b1;
        fill_random(14, 14);
        run_frame(14, 14, 1'b0, 5*14 + 7, -1);
        #1 rst = 1'b1;
        @(negedge clk);
        n_vec++; if (m_lbrst !== 2'b11) begin n_err++; $display("FAIL abort_lb_rst: %b, required 11", m_lbrst); end
        n_vec++; if (m_en !== 2'b11)    begin n_err++; $display("FAIL abort_lb_en: %b, required 11", m_en); end
        @(posedge clk); @(posedge clk); #1 rst = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        n_vec++; if (fd_cnt != 0)      begin n_err++; $display("FAIL abort_fd: %0d frame_done pulses, required 0", fd_cnt); end
        n_vec++; if (m_busy !== 1'b0)  begin n_err++; $display("FAIL abort_busy: %b, required 0", m_busy); end
        fill_random(14, 14);
        run_frame(14, 14, 1'b1, -1, -1);
        n_vec++; if (got_win.size() != 144) begin n_err++; $display("FAIL abort_next_count: %0d windows, required 144", got_win.size()); end
        for (int r = 2; r < 14; r++)
            for (int c = 2; c < 14; c++) begin
                n_vec++;
                if (k >= got_win.size() || got_win[k] !== exp_win(r, c)) begin
                    n_err++; $display("FAIL abort_next_win%0d: %b, required %b", k, (k < got_win.size()) ? got_win[k] : 9'hx, exp_win(r, c));
                end
                k++;
            end
    endtask

    task automatic test_start_busy();
        int bad = 0;
        sel = 1'b1;
        fill_random(14, 14);
        run_frame(14, 14, 1'b0, -1, 50);
        n_vec++; if (got_win.size() != 144) begin n_err++; $display("FAIL sbusy_count: %0d windows, required 144", got_win.size()); end
        for (int i = 0; i < got_win.size() && i < 144; i++) begin
            if (got_win[i] !== exp_win(2 + i / 12, 2 + i % 12)) bad++;
        end
        n_vec++; if (bad != 0) begin n_err++; $display("FAIL sbusy_windows: %0d wrong windows, required 0", bad); end
        repeat (5) @(posedge clk);
        @(negedge clk);
        n_vec++; if (fd_cnt != 1)     begin n_err++; $display("FAIL sbusy_fd_count: %0d, required 1", fd_cnt); end
        n_vec++; if (m_busy !== 1'b0) begin n_err++; $display("FAIL sbusy_restart: busy=%b, required 0", m_busy); end
    endtask

`ifdef BNN_LB_ERRCHK_EN
    task automatic test_errchk();
        sel = 1'b1;
        fill_random(14, 14);
        @(negedge clk);
        n_vec++; if (m_err !== 1'b0) begin n_err++; $display("FAIL err_pre: %b, required 0", m_err); end
        force_empty = 1'b1;
        run_frame(14, 14, 1'b0, 2*14 + 1, -1);
        @(negedge clk);
        n_vec++; if (m_err !== 1'b1) begin n_err++; $display("FAIL err_set: %b, required 1", m_err); end
        force_empty = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        n_vec++; if (m_err !== 1'b1) begin n_err++; $display("FAIL err_sticky: %b, required 1", m_err); end
        #1 rst = 1'b1;
        @(posedge clk); @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        n_vec++; if (m_err !== 1'b0) begin n_err++; $display("FAIL err_clear: %b, required 0", m_err); end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_ramp4();
        test_all_ones();
        test_random_gaps();
        test_reset_midframe();
        test_start_busy();
`ifdef BNN_LB_ERRCHK_EN
        test_errchk();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
